nibble_deframer: RTL and testbench

- Receive-side companion to the 24-bit to 4-bit nibble serializer in the encoding-to-decoding chain.
- Collects 4-bit nibbles qualified by enable, reassembles them into 24-bit words MSB-nibble first, and detects truncated frames.
- Queues complete words in a small show-ahead FIFO with a valid/ready interface for the downstream decoder.

---
 rtl/nibble_link_pkg.sv | 30 +++
 rtl/nibble_deframer_word_fifo.sv | 81 ++++++++
 rtl/nibble_deframer.sv | 102 ++++++++++
 tb/tb_nibble_deframer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_link_pkg.sv
// Shared definitions for the nibble link between the 24-bit serializer and
// the receive-side deframer.
//
// Contents:
//   WORD_W    - width of a link word
//   NIB_W     - width of one link nibble
//   N         - nibbles per word
//   NIB_ORDER - nibble ordering on the wire (most-significant nibble first)
//   cnt_width - helper sizing a counter that indexes nibbles of a word
package nibble_link_pkg;

  localparam int WORD_W = 24;
  localparam int NIB_W  = 4;
  localparam int N      = WORD_W / NIB_W;

  typedef enum logic {
    NIB_MSB_FIRST = 1'b0,
    NIB_LSB_FIRST = 1'b1
  } nib_order_e;

  // Both ends of the link agree on this ordering; the deframer is built for
  // MSB-first and shifts each new nibble in at the bottom of the word.
  localparam nib_order_e NIB_ORDER = NIB_MSB_FIRST;

  // A counter must be at least one bit wide even for a single-nibble word.
  function automatic int cnt_width(input int nibs);
    return (nibs > 1) ? $clog2(nibs) : 1;
  endfunction

endpackage

// File: rtl/nibble_deframer_word_fifo.sv
// word_fifo: small show-ahead FIFO holding reassembled words.
//
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   push        - request to write push_data
//   push_data   - word to write
//   pop_req     - downstream ready; only honoured when the FIFO is not empty
//   pop_data    - head-of-FIFO word, valid whenever valid=1
//   valid       - FIFO not empty
//   full        - FIFO holds DEPTH words
//   fill        - current occupancy (0..DEPTH)
//   dropped     - a push was refused this cycle because the FIFO was full
//
// DEPTH must be a power of two so the pointers can wrap by simple overflow.
module word_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_req,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [$clog2(DEPTH):0] DEPTH_CNT = ($clog2(DEPTH) + 1)'(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   do_pop;
  logic                   do_write;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign valid    = !empty;
  assign fill     = count;
  assign pop_data = mem[rd_ptr];

  // A pop from an empty FIFO is ignored. When full, a push only gets in if
  // the head leaves on the same edge; the write then lands in the slot the
  // head is vacating, since wr_ptr == rd_ptr when full.
  assign do_pop   = pop_req && !empty;
  assign do_write = push && (!full || do_pop);
  assign dropped  = push && full && !do_pop;

  // Pointer, occupancy and storage update; storage is cleared on reset so
  // the show-ahead output reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_write, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nibble_deframer.sv
// nibble_deframer: reassembles MSB-first link nibbles into words, flags
// truncated frames and buffers complete words for the downstream decoder.
//
// Ports:
//   clk, reset - clock and asynchronous active-high reset
//   nib_in     - link nibble, sampled when enable=1
//   enable     - nibble-valid strobe from the link
//   out_data   - head-of-FIFO word (meaningful when out_valid=1)
//   out_valid  - at least one word buffered
//   out_ready  - downstream accepts the head word
//   busy       - a partial word is being assembled
//   frame_err  - one-cycle pulse when a frame ends before its last nibble
//   overflow   - sticky: a complete word was dropped on a full FIFO
//   fill       - FIFO occupancy
module nibble_deframer #(
  parameter int WORD_W     = nibble_link_pkg::WORD_W,
  parameter int NIB_W      = nibble_link_pkg::NIB_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NIB_W-1:0]              nib_in,
  input  logic                          enable,
  output logic [WORD_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  import nibble_link_pkg::*;

  localparam int NIBS  = WORD_W / NIB_W;
  localparam int CNT_W = cnt_width(NIBS);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [WORD_W-NIB_W-1:0] shift;
  logic [WORD_W-1:0]       word_next;
  logic                    word_done;
  logic                    fifo_full;
  logic                    fifo_dropped;

  // The incoming nibble always becomes the least-significant nibble, so the
  // first nibble of a frame has migrated to the top once the word is full.
  assign word_next = {shift, nib_in};
  assign word_done = enable && (cnt == LAST_NIB);
  assign busy      = (cnt != '0);

  // Nibble counting, shift register, truncation pulse and sticky overflow.
  // A gap in enable with a partial word in hand is a truncated frame: the
  // partial word is thrown away and counting restarts on the next nibble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (enable) begin
        shift <= word_next[WORD_W-NIB_W-1:0];
        if (cnt == LAST_NIB) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (cnt != '0) begin
        frame_err <= 1'b1;
        cnt       <= '0;
        shift     <= '0;
      end
      if (fifo_dropped) begin
        overflow <= 1'b1;
      end
    end
  end

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (word_done),
    .push_data (word_next),
    .pop_req   (out_ready),
    .pop_data  (out_data),
    .valid     (out_valid),
    .full      (fifo_full),
    .fill      (fill),
    .dropped   (fifo_dropped)
  );

  // Only the drop indication matters here; full is kept on the FIFO port
  // for other users of word_fifo.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_nibble_deframer.sv
// Directed bench for nibble_deframer. Inputs are driven on the falling edge
// and outputs are observed on the falling edge, half a cycle after the
// rising edge that updated them.
module tb_nibble_deframer;

  logic        clk;
  logic        reset;
  logic [3:0]  nib_in;
  logic        enable;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        frame_err;
  logic        overflow;
  logic [2:0]  fill;

  int checks;
  int failures;
  int err_pulses;

  nibble_deframer dut (
    .clk       (clk),
    .reset     (reset),
    .nib_in    (nib_in),
    .enable    (enable),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overflow  (overflow),
    .fill      (fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // frame_err is counted once per cycle it is high; reading at the rising
  // edge sees the value from the cycle just ended.
  always @(posedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    enable = 1'b1;
    nib_in = n;
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 0; i < 6; i++) send_nib(w[23-4*i -: 4]);
  endtask

  task automatic idle();
    @(negedge clk);
    enable = 1'b0;
    nib_in = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable    = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns the head word and valid as seen now, then pops it on the next edge.
  task automatic pop_word(output logic [23:0] data, output logic vld);
    data      = out_data;
    vld       = out_valid;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; nib_in = 4'h0; out_ready = 1'b0;
    #2;
    checks++;
    if ({out_data, out_valid, busy, frame_err, overflow, fill} !== 31'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got data=%h v=%b busy=%b ferr=%b ovf=%b fill=%0d, want all 0",
               out_data, out_valid, busy, frame_err, overflow, fill);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    send_word(24'hB98EA1);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'hB98EA1 || fill !== 3'd1) begin
      failures++;
      $display("[TB] FAIL single_word: got v=%b data=%h fill=%0d, want v=1 data=b98ea1 fill=1",
               out_valid, out_data, fill);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fill !== 3'd0) begin
      failures++;
      $display("[TB] FAIL single_drain: got v=%b fill=%0d, want v=0 fill=0", out_valid, fill);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    logic        v;
    int          e0;
    e0 = err_pulses;
    out_ready = 1'b0;
    send_word(24'hB98EA1);
    send_word(24'h000000);
    idle();
    checks++;
    if (fill !== 3'd2 || out_data !== 24'hB98EA1) begin
      failures++;
      $display("[TB] FAIL b2b_fill: got fill=%0d head=%h, want fill=2 head=b98ea1", fill, out_data);
    end
    pop_word(d, v);
    checks++;
    if (v !== 1'b1 || d !== 24'hB98EA1) begin
      failures++;
      $display("[TB] FAIL b2b_pop0: got v=%b data=%h, want v=1 data=b98ea1", v, d);
    end
    pop_word(d, v);
    checks++;
    if (v !== 1'b1 || d !== 24'h000000) begin
      failures++;
      $display("[TB] FAIL b2b_pop1: got v=%b data=%h, want v=1 data=000000", v, d);
    end
    idle();
    checks++;
    if (fill !== 3'd0 || err_pulses != e0) begin
      failures++;
      $display("[TB] FAIL b2b_end: got fill=%0d frame_err pulses=%0d, want fill=0 pulses=0",
               fill, err_pulses - e0);
    end
  endtask

  task automatic test_truncation();
    logic [23:0] d;
    logic        v;
    int          e0;
    e0 = err_pulses;
    out_ready = 1'b0;
    send_nib(4'hB);
    send_nib(4'h9);
    send_nib(4'h8);
    idle();
    checks++;
    if (busy !== 1'b1 || frame_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL trunc_partial: got busy=%b ferr=%b, want busy=1 ferr=0", busy, frame_err);
    end
    idle();
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || fill !== 3'd0) begin
      failures++;
      $display("[TB] FAIL trunc_err: got ferr=%b busy=%b fill=%0d, want ferr=1 busy=0 fill=0",
               frame_err, busy, fill);
    end
    idle();
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL trunc_pulse_len: got ferr=%b, want 0", frame_err);
    end
    send_word(24'h123456);
    idle();
    pop_word(d, v);
    checks++;
    if (v !== 1'b1 || d !== 24'h123456) begin
      failures++;
      $display("[TB] FAIL trunc_next_frame: got v=%b data=%h, want v=1 data=123456", v, d);
    end
    checks++;
    if (err_pulses - e0 != 1) begin
      failures++;
      $display("[TB] FAIL trunc_pulse_count: got %0d pulses, want 1", err_pulses - e0);
    end
  endtask

  task automatic test_overflow();
    logic [23:0] d;
    logic        v;
    do_reset();
    for (int k = 1; k <= 5; k++) send_word(24'(k));
    idle();
    checks++;
    if (fill !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_set: got fill=%0d ovf=%b, want fill=4 ovf=1", fill, overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      pop_word(d, v);
      checks++;
      if (v !== 1'b1 || d !== 24'(k)) begin
        failures++;
        $display("[TB] FAIL ovf_drain%0d: got v=%b data=%h, want v=1 data=%h", k, v, d, 24'(k));
      end
    end
    pop_word(d, v);
    checks++;
    if (out_valid !== 1'b0 || fill !== 3'd0 || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sticky: got v=%b fill=%0d ovf=%b, want v=0 fill=0 ovf=1",
               out_valid, fill, overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [23:0] d;
    logic        v;
    do_reset();
    for (int k = 1; k <= 4; k++) send_word(24'(k));
    for (int i = 0; i < 5; i++) send_nib(4'h0);
    @(negedge clk);
    checks++;
    if (fill !== 3'd4) begin
      failures++;
      $display("[TB] FAIL fullpop_pre: got fill=%0d, want 4", fill);
    end
    enable = 1'b1; nib_in = 4'h5; out_ready = 1'b1;
    @(negedge clk);
    enable = 1'b0; out_ready = 1'b0;
    checks++;
    if (fill !== 3'd4 || overflow !== 1'b0 || out_data !== 24'h000002) begin
      failures++;
      $display("[TB] FAIL fullpop_accept: got fill=%0d ovf=%b head=%h, want fill=4 ovf=0 head=000002",
               fill, overflow, out_data);
    end
    for (int k = 2; k <= 5; k++) begin
      pop_word(d, v);
      checks++;
      if (v !== 1'b1 || d !== 24'(k)) begin
        failures++;
        $display("[TB] FAIL fullpop_drain%0d: got v=%b data=%h, want v=1 data=%h", k, v, d, 24'(k));
      end
    end
    idle();
    checks++;
    if (fill !== 3'd0) begin
      failures++;
      $display("[TB] FAIL fullpop_empty: got fill=%0d, want 0", fill);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_word(24'h000011);
    send_word(24'h000022);
    for (int i = 0; i < 4; i++) send_nib(4'hC);
    @(negedge clk);
    enable = 1'b0;
    checks++;
    if (busy !== 1'b1 || fill !== 3'd2) begin
      failures++;
      $display("[TB] FAIL midrst_pre: got busy=%b fill=%0d, want busy=1 fill=2", busy, fill);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_data, out_valid, busy, frame_err, overflow, fill} !== 31'd0) begin
      failures++;
      $display("[TB] FAIL midrst_clear: got data=%h v=%b busy=%b ferr=%b ovf=%b fill=%0d, want all 0",
               out_data, out_valid, busy, frame_err, overflow, fill);
    end
    @(negedge clk);
    reset = 1'b0;
    send_word(24'hABCDEF);
    idle();
    checks++;
    if (out_data !== 24'hABCDEF || fill !== 3'd1 || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_after: got data=%h fill=%0d v=%b, want data=abcdef fill=1 v=1",
               out_data, fill, out_valid);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    err_pulses = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_truncation();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
